// File: rtl/layer_compositor.sv
// Two-stage layer compositor: per-state enable table, priority select, frame-aligned state commit.
// Optional fade transition FSM is enabled by defining LAYER_COMPOSITOR_FADE_EN.
module layer_compositor #(
   parameter int NUM_LAYERS  = 4,
   parameter int ADDR_W      = 17,
   parameter int STATE_W     = 4,
   parameter int H_ACTIVE    = 640,
   parameter int V_ACTIVE    = 480,
   parameter int FADE_FRAMES = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [STATE_W-1:0]           state,
   input  logic [9:0]                   h_cnt,
   input  logic [9:0]                   v_cnt,
   input  logic [NUM_LAYERS-1:0]        layer_hit,
   input  logic [NUM_LAYERS*ADDR_W-1:0] layer_addr,
   input  logic                         cfg_we,
   input  logic [STATE_W-1:0]           cfg_state,
   input  logic [NUM_LAYERS-1:0]        cfg_mask,
   output logic [ADDR_W-1:0]            pixel_addr,
   output logic                         not_blank,
   output logic [STATE_W-1:0]           active_state,
   output logic                         frame_start,
   output logic [3:0]                   fade_level,
   output logic                         busy
);
   localparam int DEPTH = 1 << STATE_W;
   localparam logic [9:0] H_LIM = 10'(H_ACTIVE);
   localparam logic [9:0] V_LIM = 10'(V_ACTIVE);

   logic [NUM_LAYERS-1:0]             tbl [DEPTH];
   logic                              frame_cyc;
   logic [NUM_LAYERS-1:0]             s1_eff;
   logic [NUM_LAYERS-1:0][ADDR_W-1:0] s1_addr;
   logic                              s1_act;
   logic                              sel_hit;
   logic [ADDR_W-1:0]                 sel_addr;
   logic                              blank_force;
   logic [STATE_W-1:0]                act_d;

   assign frame_cyc = (h_cnt == 10'd0) && (v_cnt == 10'd0);

   // Writes land at the clock edge, so a same-cycle lookup of that entry sees the old mask.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) tbl[i] <= '1;
      end else if (cfg_we) begin
         tbl[cfg_state] <= cfg_mask;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_eff  <= '0;
         s1_addr <= '0;
         s1_act  <= 1'b0;
      end else begin
         s1_eff  <= layer_hit & tbl[active_state];
         s1_addr <= layer_addr;
         s1_act  <= (h_cnt < H_LIM) && (v_cnt < V_LIM);
      end
   end

   // Walk from highest to lowest index so the lowest set layer wins.
   always_comb begin
      sel_hit  = 1'b0;
      sel_addr = '0;
      for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
         if (s1_eff[i]) begin
            sel_hit  = 1'b1;
            sel_addr = s1_addr[i];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pixel_addr   <= '0;
         not_blank    <= 1'b0;
         frame_start  <= 1'b0;
         active_state <= '0;
      end else begin
         pixel_addr   <= (sel_hit && s1_act) ? sel_addr : '0;
         not_blank    <= sel_hit && s1_act && !blank_force;
         frame_start  <= frame_cyc;
         active_state <= act_d;
      end
   end

`ifdef LAYER_COMPOSITOR_FADE_EN
   localparam logic [3:0] FADE_MAX = 4'(FADE_FRAMES);

   typedef enum logic [1:0] {IDLE, FADE_OUT, FADE_IN} fade_state_t;
   fade_state_t fs_q, fs_d;
   logic [3:0]  level_q, level_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fs_q    <= IDLE;
         level_q <= 4'd0;
      end else begin
         fs_q    <= fs_d;
         level_q <= level_d;
      end
   end

   // The FSM only advances on frame-start cycles; the commit happens one frame after full fade.
   always_comb begin
      fs_d    = fs_q;
      level_d = level_q;
      act_d   = active_state;
      if (frame_cyc) begin
         case (fs_q)
            IDLE: begin
               if (state != active_state) begin
                  fs_d    = FADE_OUT;
                  level_d = 4'd1;
               end
            end
            FADE_OUT: begin
               if (level_q < FADE_MAX) begin
                  level_d = level_q + 4'd1;
               end else begin
                  act_d = state;
                  fs_d  = FADE_IN;
               end
            end
            FADE_IN: begin
               if (state != active_state) begin
                  fs_d = FADE_OUT;
                  if (level_q < FADE_MAX) level_d = level_q + 4'd1;
               end else begin
                  level_d = level_q - 4'd1;
                  if (level_q == 4'd1) fs_d = IDLE;
               end
            end
            default: fs_d = IDLE;
         endcase
      end
   end

   assign fade_level  = level_q;
   assign busy        = (fs_q != IDLE);
   assign blank_force = (level_q == FADE_MAX);
`else
   assign act_d       = frame_cyc ? state : active_state;
   assign fade_level  = 4'd0;
   assign busy        = 1'b0;
   assign blank_force = 1'b0;
`endif

endmodule

// File: tb/tb_layer_compositor.sv
// Directed-vector bench for layer_compositor; the fade scenario runs when LAYER_COMPOSITOR_FADE_EN is defined.
module tb_layer_compositor;
   logic              clk = 1'b0;
   logic              rst;
   logic [3:0]        state;
   logic [9:0]        h_cnt, v_cnt;
   logic [3:0]        layer_hit;
   logic [3:0][16:0]  addrs;
   logic              cfg_we;
   logic [3:0]        cfg_state;
   logic [3:0]        cfg_mask;
   logic [16:0]       pixel_addr;
   logic              not_blank;
   logic [3:0]        active_state;
   logic              frame_start;
   logic [3:0]        fade_level;
   logic              busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   layer_compositor #(.FADE_FRAMES(2)) dut (
      .clk(clk), .rst(rst), .state(state), .h_cnt(h_cnt), .v_cnt(v_cnt),
      .layer_hit(layer_hit), .layer_addr(addrs), .cfg_we(cfg_we),
      .cfg_state(cfg_state), .cfg_mask(cfg_mask), .pixel_addr(pixel_addr),
      .not_blank(not_blank), .active_state(active_state),
      .frame_start(frame_start), .fade_level(fade_level), .busy(busy)
   );

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({pixel_addr, not_blank, frame_start} !== 19'd0) begin
         n_fail++; $display("FAIL reset_out: got addr=%h nb=%b fs=%b, want 0", pixel_addr, not_blank, frame_start);
      end
      n_checks++;
      if ({active_state, fade_level, busy} !== 9'd0) begin
         n_fail++; $display("FAIL reset_state: got act=%h lvl=%h busy=%b, want 0", active_state, fade_level, busy);
      end
      rst = 1'b0;
      layer_hit = 4'b0100; addrs[2] = 17'h1234;
      cyc(); cyc();
      n_checks++;
      if (pixel_addr !== 17'h1234 || not_blank !== 1'b1) begin
         n_fail++; $display("FAIL single_layer: got addr=%h nb=%b, want 1234/1", pixel_addr, not_blank);
      end
   endtask

   task automatic test_priority();
      layer_hit = 4'b1010; addrs[1] = 17'h00AA; addrs[3] = 17'h00BB;
      cyc(); cyc();
      n_checks++;
      if (pixel_addr !== 17'h00AA || not_blank !== 1'b1) begin
         n_fail++; $display("FAIL priority: got addr=%h nb=%b, want 00aa/1", pixel_addr, not_blank);
      end
      layer_hit = 4'b0000;
      cyc(); cyc();
      n_checks++;
      if (pixel_addr !== 17'h0 || not_blank !== 1'b0) begin
         n_fail++; $display("FAIL no_hit: got addr=%h nb=%b, want 0/0", pixel_addr, not_blank);
      end
   endtask

   task automatic test_table_write();
      // Write entry 0 while a pixel looks it up: that pixel still uses the old all-ones mask.
      cfg_we = 1'b1; cfg_state = 4'd0; cfg_mask = 4'b1000;
      layer_hit = 4'b0100; addrs[2] = 17'h1234;
      cyc();
      cfg_we = 1'b0; layer_hit = 4'b0110;
      cyc();
      n_checks++;
      if (pixel_addr !== 17'h1234 || not_blank !== 1'b1) begin
         n_fail++; $display("FAIL write_read_old: got addr=%h nb=%b, want 1234/1", pixel_addr, not_blank);
      end
      cyc();
      n_checks++;
      if (pixel_addr !== 17'h0 || not_blank !== 1'b0) begin
         n_fail++; $display("FAIL masked: got addr=%h nb=%b, want 0/0", pixel_addr, not_blank);
      end
      layer_hit = 4'b1000;
      cyc(); cyc();
      n_checks++;
      if (pixel_addr !== 17'h00BB || not_blank !== 1'b1) begin
         n_fail++; $display("FAIL mask_pass: got addr=%h nb=%b, want 00bb/1", pixel_addr, not_blank);
      end
      cfg_we = 1'b1; cfg_mask = 4'b1111;
      cyc();
      cfg_we = 1'b0;
   endtask

   task automatic test_active_area();
      layer_hit = 4'b0001; addrs[0] = 17'h0055;
      h_cnt = 10'd640;
      cyc(); cyc();
      n_checks++;
      if (pixel_addr !== 17'h0 || not_blank !== 1'b0) begin
         n_fail++; $display("FAIL h_edge_out: got addr=%h nb=%b, want 0/0", pixel_addr, not_blank);
      end
      h_cnt = 10'd639; v_cnt = 10'd479;
      cyc(); cyc();
      n_checks++;
      if (pixel_addr !== 17'h0055 || not_blank !== 1'b1) begin
         n_fail++; $display("FAIL last_pixel: got addr=%h nb=%b, want 0055/1", pixel_addr, not_blank);
      end
      h_cnt = 10'd5; v_cnt = 10'd480;
      cyc(); cyc();
      n_checks++;
      if (not_blank !== 1'b0) begin
         n_fail++; $display("FAIL v_edge_out: got nb=%b, want 0", not_blank);
      end
      v_cnt = 10'd5;
   endtask

   task automatic frame_pulse();
      h_cnt = 10'd0; v_cnt = 10'd0;
      cyc();
      h_cnt = 10'd5; v_cnt = 10'd5;
   endtask

`ifndef LAYER_COMPOSITOR_FADE_EN
   task automatic test_commit();
      cfg_we = 1'b1; cfg_state = 4'd2; cfg_mask = 4'b0100;
      cyc();
      cfg_we = 1'b0;
      state = 4'd5;
      cyc();
      state = 4'd2;
      repeat (3) cyc();
      n_checks++;
      if (active_state !== 4'd0 || frame_start !== 1'b0) begin
         n_fail++; $display("FAIL mid_frame_hold: got act=%h fs=%b, want 0/0", active_state, frame_start);
      end
      h_cnt = 10'd0; v_cnt = 10'd0;
      cyc();
      n_checks++;
      if (active_state !== 4'd2 || frame_start !== 1'b1) begin
         n_fail++; $display("FAIL commit: got act=%h fs=%b, want 2/1", active_state, frame_start);
      end
      h_cnt = 10'd5; v_cnt = 10'd5;
      cyc();
      n_checks++;
      if (frame_start !== 1'b0) begin
         n_fail++; $display("FAIL fs_pulse: got fs=%b, want 0", frame_start);
      end
      layer_hit = 4'b0011; addrs[0] = 17'h0011; addrs[1] = 17'h0022;
      cyc(); cyc();
      n_checks++;
      if (not_blank !== 1'b0 || pixel_addr !== 17'h0) begin
         n_fail++; $display("FAIL new_mask_block: got addr=%h nb=%b, want 0/0", pixel_addr, not_blank);
      end
      layer_hit = 4'b0111; addrs[2] = 17'h0033;
      state = 4'd0;
      cyc(); cyc();
      n_checks++;
      if (pixel_addr !== 17'h0033 || not_blank !== 1'b1) begin
         n_fail++; $display("FAIL new_mask_pass: got addr=%h nb=%b, want 0033/1", pixel_addr, not_blank);
      end
      n_checks++;
      if (active_state !== 4'd2 || fade_level !== 4'd0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL no_fade: got act=%h lvl=%h busy=%b, want 2/0/0", active_state, fade_level, busy);
      end
   endtask
`else
   task automatic test_fade();
      layer_hit = 4'b0001; addrs[0] = 17'h0055;
      state = 4'd3;
      cyc();
      n_checks++;
      if (busy !== 1'b0 || active_state !== 4'd0) begin
         n_fail++; $display("FAIL fade_pre: got busy=%b act=%h, want 0/0", busy, active_state);
      end
      frame_pulse();
      n_checks++;
      if (fade_level !== 4'd1 || busy !== 1'b1 || active_state !== 4'd0) begin
         n_fail++; $display("FAIL fade_f1: got lvl=%h busy=%b act=%h, want 1/1/0", fade_level, busy, active_state);
      end
      frame_pulse();
      n_checks++;
      if (fade_level !== 4'd2 || active_state !== 4'd0) begin
         n_fail++; $display("FAIL fade_f2: got lvl=%h act=%h, want 2/0", fade_level, active_state);
      end
      cyc(); cyc();
      n_checks++;
      if (not_blank !== 1'b0) begin
         n_fail++; $display("FAIL fade_blank: got nb=%b, want 0", not_blank);
      end
      frame_pulse();
      n_checks++;
      if (active_state !== 4'd3 || fade_level !== 4'd2 || busy !== 1'b1) begin
         n_fail++; $display("FAIL fade_f3: got act=%h lvl=%h busy=%b, want 3/2/1", active_state, fade_level, busy);
      end
      frame_pulse();
      n_checks++;
      if (fade_level !== 4'd1 || busy !== 1'b1) begin
         n_fail++; $display("FAIL fade_f4: got lvl=%h busy=%b, want 1/1", fade_level, busy);
      end
      cyc(); cyc();
      n_checks++;
      if (not_blank !== 1'b1 || pixel_addr !== 17'h0055) begin
         n_fail++; $display("FAIL fade_visible: got addr=%h nb=%b, want 0055/1", pixel_addr, not_blank);
      end
      frame_pulse();
      n_checks++;
      if (fade_level !== 4'd0 || busy !== 1'b0 || active_state !== 4'd3) begin
         n_fail++; $display("FAIL fade_f5: got lvl=%h busy=%b act=%h, want 0/0/3", fade_level, busy, active_state);
      end
   endtask
`endif

   task automatic test_reset_mid_frame();
      layer_hit = 4'b0001; addrs[0] = 17'h0055;
      cfg_we = 1'b1; cfg_state = 4'd0; cfg_mask = 4'b0000;
      cyc();
      cfg_we = 1'b0;
      #1 rst = 1'b1;
      #1;
      n_checks++;
      if (active_state !== 4'd0 || not_blank !== 1'b0 || pixel_addr !== 17'h0) begin
         n_fail++; $display("FAIL async_reset: got act=%h nb=%b addr=%h, want 0/0/0", active_state, not_blank, pixel_addr);
      end
      #1 rst = 1'b0;
      cyc(); cyc();
      n_checks++;
      if (pixel_addr !== 17'h0055 || not_blank !== 1'b1 || active_state !== 4'd0) begin
         n_fail++; $display("FAIL resume: got addr=%h nb=%b act=%h, want 0055/1/0", pixel_addr, not_blank, active_state);
      end
   endtask

   initial begin
      rst = 1'b1; state = 4'd0; h_cnt = 10'd5; v_cnt = 10'd5;
      layer_hit = 4'b0000; addrs = '0;
      cfg_we = 1'b0; cfg_state = 4'd0; cfg_mask = 4'b0000;
      test_reset();
      test_priority();
      test_table_write();
      test_active_area();
`ifndef LAYER_COMPOSITOR_FADE_EN
      test_commit();
`else
      test_fade();
`endif
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/layer_compositor.md
Name: layer_compositor

Overview:
- Parametrised, pipelined successor to the per-state sprite-layer mux in the display path.
- Composites NUM_LAYERS sprite/tile layer sources into one frame-buffer address plus a not_blank flag, using a runtime-writable per-state layer-enable table.
- Game-state changes are committed only at frame boundaries, so no frame is torn.
- Sits between the draw_* layer generators and the VGA colour/ROM stage.

Parameters:
- NUM_LAYERS, 4, number of layer inputs; index 0 has highest priority.
- ADDR_W, 17, width of each pixel address.
- STATE_W, 4, game-state width; the table holds 2**STATE_W entries.
- H_ACTIVE, 640, visible horizontal pixels.
- V_ACTIVE, 480, visible lines.
- FADE_FRAMES, 8, frames per fade half; legal range 1..15.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  reset.
- state  in  STATE_W  requested game state.
- h_cnt  in  10  horizontal counter.
- v_cnt  in  10  vertical counter.
- layer_hit  in  NUM_LAYERS  per-layer "pixel belongs to object".
- layer_addr  in  NUM_LAYERS*ADDR_W  per-layer address; layer i occupies bits [i*ADDR_W +: ADDR_W].
- cfg_we  in  1  table write strobe.
- cfg_state  in  STATE_W  table entry to write.
- cfg_mask  in  NUM_LAYERS  layer-enable mask to write.
- pixel_addr  out  ADDR_W  composited address.
- not_blank  out  1  a layer is drawn at this pixel.
- active_state  out  STATE_W  committed state.
- frame_start  out  1  one-cycle pulse on frame start.
- fade_level  out  4  fade depth; 0 = full brightness.
- busy  out  1  transition in progress.

Behaviour:
- Reset: rst, asynchronous, active-high; clock clk. On reset:
  - pixel_addr=0, not_blank=0, active_state=0, frame_start=0, fade_level=0, busy=0.
  - Every table entry = all ones.
  - Pipeline registers cleared.
  - Reset mid-frame: compositing resumes with state 0 on the next cycle; no frame-start wait.
- Frame start: cycle in which h_cnt==0 && v_cnt==0. frame_start is registered, so it asserts the cycle after.
- Pipeline, latency 2 cycles from h_cnt/v_cnt/layer_* to outputs:
  - Stage 1 registers eff = layer_hit & table[active_state], all layer_addr, and the in_active flag (h_cnt<H_ACTIVE && v_cnt<V_ACTIVE).
  - Stage 2 selects the lowest index i with eff[i]=1: pixel_addr=addr[i], not_blank=1.
  - If no layer is selected or !in_active: not_blank=0 and pixel_addr=0. No latching of stale addresses.
- Table write:
  - cfg_we writes cfg_mask into entry cfg_state; takes effect for stage-1 lookups from the next cycle.
  - A write to the entry being read in the same cycle: the read returns the old value.
- State commit without FADE_EN: at frame start, active_state <= state if different. New mask applies from the next cycle.
- Changes to state mid-frame are ignored until the next frame start. The last value present at frame start wins.

Optional Feature:
- Macro: LAYER_COMPOSITOR_FADE_EN.
- When defined, an FSM {IDLE, FADE_OUT, FADE_IN} is clocked at frame starts:
  - IDLE: if state != active_state -> FADE_OUT, fade_level=1.
  - FADE_OUT: fade_level+1 per frame start until it equals FADE_FRAMES. At the following frame start, active_state <= state (latest), then -> FADE_IN.
  - FADE_IN: fade_level-1 per frame start; -> IDLE when it reaches 0.
  - If state differs from active_state at a frame start while in FADE_IN: -> FADE_OUT, counting up from the current level.
  - busy=1 in FADE_OUT/FADE_IN.
  - not_blank forced 0 while fade_level==FADE_FRAMES.
- When undefined: fade_level tied to 0, busy tied to 0, immediate commit as above.

Test Plan:
- Reset, table all ones, only layer_hit[2]=1 with addr2=0x1234 at h=5,v=5 -> two cycles later pixel_addr=0x1234, not_blank=1.
- layer_hit=4'b1010, addr1=0x00AA, addr3=0x00BB -> pixel_addr=0x00AA (lower index wins).
- cfg_we to state 0 with mask 4'b1000, then layer_hit=4'b0110 -> not_blank=0, pixel_addr=0.
- h_cnt=640 with layer_hit=4'b0001 -> not_blank=0.
- Without fade: state 0->2 at mid-frame with table[2]=4'b0100 -> active_state stays 0 until the cycle after the next h=0,v=0; then only layer 2 passes.
- Fade, FADE_FRAMES=2, state 0->3:
  - fade_level 1,2 over two frame starts; blank during level 2.
  - active_state=3 at the third frame start.
  - Level steps 1,0 over the next two frame starts; busy falls when level reaches 0.
